tube_ph_arbiter: RTL and testbench
==================================

// Module: tube_ph_arbiter
// PURPOSE
//   Parasite-side write scheduler for a parasite-to-host single-byte Tube buffer.
//   Shares the buffer's one write port among N_REQ requesters in round-robin order.
//   Generates the p_data / p_selectData / p_westb_b write cycle and never writes while the buffer is full.
//   The write is committed on the rising edge of p_westb_b, in state HOLD.
// PARAMETERS
//   N_REQ        4   number of requesters (2..8)
//   STROBE_CYC   2   cycles p_westb_b is held low (1..15)
//   ACK_TIMEOUT  15  max cycles in WAIT_ACK for p_full to be seen high (1..255)
// PORTS
//   p_clk         in   1        parasite clock; all state changes on its rising edge
//   p_rst         in   1        synchronous reset, active-high
//   req_valid     in   N_REQ    per-requester write request
//   req_data      in   8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
//   req_ready     out  N_REQ    one-cycle pulse: that requester's byte is committed
//   p_full        in   1        buffer full flag; asynchronous to p_clk
//   p_data        out  8        byte to buffer
//   p_selectData  out  1        buffer select
//   p_westb_b     out  1        write strobe, active-low
//   grant_id      out  3        index of current or last granted requester
//   busy          out  1        high in every state except IDLE
//   err_ack       out  1        sticky: a timeout occurred in WAIT_ACK
// BEHAVIOUR
//   - Reset values: p_westb_b=1, p_selectData=0, p_data=0, req_ready=0, grant_id=0, busy=0, err_ack=0.
//     Also state=IDLE, rr_ptr=N_REQ-1, full_sync=2'b11 (treated as full), counters=0.
//   - Reset applies at the next p_clk edge from any state. An in-flight strobe is abandoned with p_westb_b=1.
//     No req_ready is issued for an abandoned transfer.
//   - p_full passes through a 2-flop synchroniser; fullS = second stage. All decisions use fullS only.
//   - All outputs are registered.
//   - FSM:
//     IDLE:     if fullS=0 and any req_valid: pick winner, latch winner's data into p_data, set grant_id -> SETUP.
//               Winner = first asserted index scanning rr_ptr+1 .. rr_ptr+N_REQ (mod N_REQ).
//     SETUP:    p_selectData=1, p_westb_b=1 for 1 cycle -> STROBE.
//     STROBE:   p_selectData=1, p_westb_b=0 for STROBE_CYC cycles -> HOLD.
//     HOLD:     p_westb_b=1 (rising edge commits the byte), p_selectData=1, req_ready[grant_id]=1 for 1 cycle.
//               Also rr_ptr<=grant_id -> WAIT_ACK.
//     WAIT_ACK: p_selectData=0. On fullS=1 -> IDLE.
//               If ACK_TIMEOUT cycles elapse first -> err_ack<=1, then IDLE.
//   - Latency, STROBE_CYC=2, buffer empty, request sampled in IDLE at edge 0:
//     SETUP at 1, STROBE at 2-3, HOLD at 4 with req_ready high, WAIT_ACK from 5.
//   - WAIT_ACK exists so the stale fullS=0 in the synchroniser cannot cause a double write.
//   - A new grant therefore needs fullS to go 1 and then 0: the host must read the byte.
//   - p_data is latched at grant. req_data may change after grant without effect.
//   - Requesters hold req_valid until req_ready.
//     Dropping req_valid after grant does not cancel the transfer; req_ready still pulses.
//   - A requester still asserting req_valid after its req_ready is treated as a new request.
//     It gets lowest priority next round.
//   - Simultaneous requests: strict round-robin; no requester is starved while others keep requesting.
//   - p_full rising during SETUP or STROBE does not abort the write. The buffer itself resolves overrun.
//   - At most one req_ready bit is high in any cycle.
//   - err_ack is cleared only by p_rst.
// TESTING
//   1. Reset, then req_valid=4'b0001, data 0x5A, p_full=0.
//      -> p_westb_b low at cycles 2-3; p_data=0x5A; req_ready[0] at cycle 4; no second strobe.
//   2. All four requesting continuously; p_full toggles 1 then 0 three cycles after each write.
//      -> grants in order 0,1,2,3,0; each req_ready once per grant.
//   3. p_full held at 1; req_valid=4'b0100. -> no strobe and busy=0.
//      Release p_full -> grant 2 three cycles later (synchroniser plus IDLE sample).
//   4. Write completes, p_full held at 0 for 20 cycles.
//      -> err_ack=1 at WAIT_ACK cycle 15; back to IDLE; err_ack stays 1 until p_rst.
//   5. Assert p_rst during STROBE. -> next edge: p_westb_b=1, p_selectData=0, busy=0, no req_ready.
//      After release, requester 0 wins first.
//   6. Requester 1 changes req_data after grant and drops req_valid in STROBE.
//      -> original byte written; req_ready[1] still pulses.

Source files
------------

// File: rtl/tube_ph_arbiter.sv
// Round-robin write scheduler for the parasite-to-host Tube byte buffer.
// Drives the select/strobe cycle and waits for the host to take the byte before granting again.
module tube_ph_arbiter #(
  parameter int N_REQ       = 4,
  parameter int STROBE_CYC  = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               p_clk,
  input  logic               p_rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               p_full,
  output logic [7:0]         p_data,
  output logic               p_selectData,
  output logic               p_westb_b,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic               err_ack
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] STROBE   = 3'd2;
  localparam logic [2:0] HOLD     = 3'd3;
  localparam logic [2:0] WAIT_ACK = 3'd4;

  localparam logic [2:0] RR_INIT = 3'(N_REQ - 1);

  logic [2:0]       state;
  logic [2:0]       rr_ptr;
  logic [3:0]       strobe_cnt;
  logic [7:0]       ack_cnt;
  logic             full_meta;
  logic             full_s;
  logic             win_found;
  logic [2:0]       win_idx;
  logic [3:0]       cand;
  logic [7:0]       win_byte;
  logic [N_REQ-1:0] grant_onehot;

  // Scan rr_ptr+1 .. rr_ptr+N_REQ (mod N_REQ) and take the first asserted request.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 4'd0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      for (int j = 0; j < N_REQ; j++) begin
        if (!win_found && req_valid[j] && cand == 4'(j)) begin
          win_found = 1'b1;
          win_idx   = 3'(j);
        end
      end
    end
  end

  always_comb begin
    win_byte     = 8'h00;
    grant_onehot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (win_idx == 3'(j)) win_byte = req_data[8*j +: 8];
      if (grant_id == 3'(j)) grant_onehot[j] = 1'b1;
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      state        <= IDLE;
      rr_ptr       <= RR_INIT;
      strobe_cnt   <= 4'd0;
      ack_cnt      <= 8'd0;
      full_meta    <= 1'b1;
      full_s       <= 1'b1;
      p_data       <= 8'h00;
      p_selectData <= 1'b0;
      p_westb_b    <= 1'b1;
      req_ready    <= '0;
      grant_id     <= 3'd0;
      busy         <= 1'b0;
      err_ack      <= 1'b0;
    end else begin
      full_meta <= p_full;
      full_s    <= full_meta;
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (!full_s && win_found) begin
            p_data       <= win_byte;
            grant_id     <= win_idx;
            p_selectData <= 1'b1;
            p_westb_b    <= 1'b1;
            busy         <= 1'b1;
            state        <= SETUP;
          end
        end
        SETUP: begin
          p_westb_b  <= 1'b0;
          strobe_cnt <= 4'd0;
          state      <= STROBE;
        end
        STROBE: begin
          if (strobe_cnt == 4'(STROBE_CYC - 1)) begin
            p_westb_b <= 1'b1;
            req_ready <= grant_onehot;
            state     <= HOLD;
          end else begin
            strobe_cnt <= strobe_cnt + 4'd1;
          end
        end
        HOLD: begin
          rr_ptr       <= grant_id;
          p_selectData <= 1'b0;
          ack_cnt      <= 8'd0;
          state        <= WAIT_ACK;
        end
        // Wait for the host to see the byte so the stale empty flag cannot trigger a second write.
        WAIT_ACK: begin
          if (full_s) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (ack_cnt == 8'(ACK_TIMEOUT - 1)) begin
            err_ack <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + 8'd1;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          p_selectData <= 1'b0;
          p_westb_b    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tube_ph_arbiter.sv
// Directed and randomized checks of tube_ph_arbiter against a round-robin transaction model.
module tb_tube_ph_arbiter;

  localparam int N = 4;

  logic           p_clk = 1'b0;
  logic           p_rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           p_full;
  logic [7:0]     p_data;
  logic           p_selectData;
  logic           p_westb_b;
  logic [2:0]     grant_id;
  logic           busy;
  logic           err_ack;

  int checks   = 0;
  int failures = 0;

  bit         ok;
  int         exp_id;
  int         last_id;
  logic [N-1:0] pend;
  logic [7:0] dat [N];

  tube_ph_arbiter #(.N_REQ(N), .STROBE_CYC(2), .ACK_TIMEOUT(15)) dut (
    .p_clk        (p_clk),
    .p_rst        (p_rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .p_full       (p_full),
    .p_data       (p_data),
    .p_selectData (p_selectData),
    .p_westb_b    (p_westb_b),
    .grant_id     (grant_id),
    .busy         (busy),
    .err_ack      (err_ack)
  );

  always #5 p_clk = ~p_clk;

  task automatic tick();
    @(posedge p_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic [N-1:0] valid, input logic full);
    p_rst     = rst;
    req_valid = valid;
    p_full    = full;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // which=0: wait for p_selectData high; which=1: wait for any req_ready bit
  task automatic waitFor(input string tag, input int which, output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ((which == 0 && p_selectData) || (which == 1 && req_ready != '0)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s observed=timeout expected=event", tag);
    end
  endtask

  initial begin
    req_data = '0;
    applyStimulus(1'b1, 4'b0000, 1'b0);
    tick();
    tick();
    checkOutput("rst_westb", 32'(p_westb_b), 1);
    checkOutput("rst_sel", 32'(p_selectData), 0);
    checkOutput("rst_data", 32'(p_data), 0);
    checkOutput("rst_ready", 32'(req_ready), 0);
    checkOutput("rst_grant", 32'(grant_id), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_err", 32'(err_ack), 0);

    // Single write then ack timeout: the synchroniser needs two edges, grant on the third.
    req_data[7:0] = 8'h5A;
    applyStimulus(1'b0, 4'b0001, 1'b0);
    tick();
    tick();
    checkOutput("t1_pre_grant_sel", 32'(p_selectData), 0);
    tick();
    checkOutput("t1_setup_sel", 32'(p_selectData), 1);
    checkOutput("t1_setup_westb", 32'(p_westb_b), 1);
    checkOutput("t1_setup_busy", 32'(busy), 1);
    checkOutput("t1_setup_data", 32'(p_data), 'h5A);
    checkOutput("t1_setup_grant", 32'(grant_id), 0);
    tick();
    checkOutput("t1_strobe_a", 32'(p_westb_b), 0);
    tick();
    checkOutput("t1_strobe_b", 32'(p_westb_b), 0);
    checkOutput("t1_strobe_ready", 32'(req_ready), 0);
    tick();
    checkOutput("t1_hold_westb", 32'(p_westb_b), 1);
    checkOutput("t1_hold_ready", 32'(req_ready), 1);
    checkOutput("t1_hold_sel", 32'(p_selectData), 1);
    req_valid = 4'b0000;
    tick();
    checkOutput("t1_wait_ready", 32'(req_ready), 0);
    checkOutput("t1_wait_sel", 32'(p_selectData), 0);
    checkOutput("t1_wait_busy", 32'(busy), 1);
    for (int i = 0; i < 14; i++) begin
      tick();
      checkOutput("t1_no_second_strobe", 32'(p_westb_b), 1);
    end
    checkOutput("t4_err_before", 32'(err_ack), 0);
    checkOutput("t4_busy_before", 32'(busy), 1);
    tick();
    checkOutput("t4_err_set", 32'(err_ack), 1);
    checkOutput("t4_idle_busy", 32'(busy), 0);
    tick();
    tick();
    checkOutput("t4_err_sticky", 32'(err_ack), 1);
    checkOutput("t4_idle_westb", 32'(p_westb_b), 1);

    // Requester 1 changes its byte and drops valid after grant.
    req_data[15:8] = 8'hC3;
    req_valid = 4'b0010;
    tick();
    checkOutput("t6_grant_sel", 32'(p_selectData), 1);
    checkOutput("t6_grant_id", 32'(grant_id), 1);
    req_data[15:8] = 8'h3C;
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    checkOutput("t6_hold_data", 32'(p_data), 'hC3);
    checkOutput("t6_hold_ready", 32'(req_ready), 'b0010);
    checkOutput("t6_err_sticky", 32'(err_ack), 1);
    p_full = 1'b1;
    repeat (4) tick();
    checkOutput("t6_ack_idle", 32'(busy), 0);

    // Continuous requests from all four: strict round-robin from index 0.
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'(8'h10 + i);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    tick();
    tick();
    checkOutput("t2_rst_clears_err", 32'(err_ack), 0);
    p_rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      waitFor("t2_wait_grant", 0, ok);
      checkOutput("t2_grant_id", 32'(grant_id), g % N);
      checkOutput("t2_grant_data", 32'(p_data), 'h10 + (g % N));
      waitFor("t2_wait_ready", 1, ok);
      checkOutput("t2_ready", 32'(req_ready), 1 << (g % N));
      repeat (3) tick();
      p_full = 1'b1;
      repeat (3) tick();
      checkOutput("t2_ready_once", 32'(req_ready), 0);
      p_full = 1'b0;
    end

    // Full held high blocks the grant; release gives grant three edges later.
    applyStimulus(1'b1, 4'b0100, 1'b1);
    tick();
    tick();
    p_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("t3_blocked_westb", 32'(p_westb_b), 1);
      checkOutput("t3_blocked_busy", 32'(busy), 0);
    end
    p_full = 1'b0;
    tick();
    tick();
    checkOutput("t3_sync_sel", 32'(p_selectData), 0);
    tick();
    checkOutput("t3_grant_sel", 32'(p_selectData), 1);
    checkOutput("t3_grant_id", 32'(grant_id), 2);
    waitFor("t3_wait_ready", 1, ok);
    checkOutput("t3_ready", 32'(req_ready), 'b0100);
    req_valid = 4'b0000;
    p_full = 1'b1;
    repeat (4) tick();

    // Reset during STROBE abandons the write and restores the round-robin pointer.
    applyStimulus(1'b1, 4'b0011, 1'b0);
    tick();
    tick();
    p_rst = 1'b0;
    waitFor("t5_wait_first", 0, ok);
    checkOutput("t5_first_grant", 32'(grant_id), 0);
    waitFor("t5_wait_first_ready", 1, ok);
    req_valid = 4'b0010;
    p_full = 1'b1;
    repeat (4) tick();
    req_valid = 4'b0011;
    p_full = 1'b0;
    waitFor("t5_wait_second", 0, ok);
    checkOutput("t5_second_grant", 32'(grant_id), 1);
    tick();
    checkOutput("t5_in_strobe", 32'(p_westb_b), 0);
    p_rst = 1'b1;
    tick();
    checkOutput("t5_rst_westb", 32'(p_westb_b), 1);
    checkOutput("t5_rst_sel", 32'(p_selectData), 0);
    checkOutput("t5_rst_busy", 32'(busy), 0);
    checkOutput("t5_rst_ready", 32'(req_ready), 0);
    tick();
    checkOutput("t5_rst_ready_b", 32'(req_ready), 0);
    p_rst = 1'b0;
    tick();
    tick();
    checkOutput("t5_no_ready_a", 32'(req_ready), 0);
    tick();
    checkOutput("t5_after_rst_sel", 32'(p_selectData), 1);
    checkOutput("t5_after_rst_grant", 32'(grant_id), 0);
    waitFor("t5_wait_ready", 1, ok);
    checkOutput("t5_ready", 32'(req_ready), 'b0001);
    req_valid = 4'b0000;
    p_full = 1'b1;
    repeat (4) tick();

    // Randomized rounds: the host holds the buffer full while the request set changes.
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick();
    tick();
    p_rst = 1'b0;
    pend = '0;
    last_id = N - 1;
    for (int i = 0; i < N; i++) dat[i] = 8'h00;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          dat[i] = 8'($urandom);
        end
      end
      for (int i = 0; i < N; i++) req_data[8*i +: 8] = dat[i];
      req_valid = pend;
      tick();
      p_full = 1'b0;
      if (pend == '0) begin
        repeat (6) tick();
        checkOutput("rnd_idle_busy", 32'(busy), 0);
        checkOutput("rnd_idle_westb", 32'(p_westb_b), 1);
        p_full = 1'b1;
        repeat (3) tick();
      end else begin
        exp_id = -1;
        for (int k = 1; k <= N; k++) begin
          if (exp_id < 0 && pend[(last_id + k) % N]) exp_id = (last_id + k) % N;
        end
        waitFor("rnd_wait_grant", 0, ok);
        checkOutput("rnd_grant_id", 32'(grant_id), exp_id);
        waitFor("rnd_wait_ready", 1, ok);
        checkOutput("rnd_ready", 32'(req_ready), 1 << exp_id);
        checkOutput("rnd_data", 32'(p_data), 32'(dat[exp_id]));
        checkOutput("rnd_westb_high", 32'(p_westb_b), 1);
        pend[exp_id] = 1'b0;
        last_id = exp_id;
        req_valid = pend;
        p_full = 1'b1;
        repeat (4) tick();
      end
    end
    checkOutput("rnd_no_err", 32'(err_ack), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
